// File: rtl/knn_pkg.sv
// Shared types and sizes for the KNN training-point read path.
// Included by the streamer, its row FIFO and the bus interface.
package knn_pkg;

  localparam int REGISTER_SIZE = 11;
  localparam int DEPTH         = 128;
  localparam int LANES         = 4;
  localparam int ADDR_W        = $clog2(DEPTH / LANES);
  localparam int NUM_W         = 8;

  typedef struct packed {
    logic [REGISTER_SIZE-1:0] x;
    logic [REGISTER_SIZE-2:0] y;
  } point_t;

  typedef struct packed {
    point_t [LANES-1:0] p;
    logic   [LANES-1:0] mask;
    logic               last;
  } row_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_e;

  function automatic logic [NUM_W-1:0] clamp_n(
    input logic [NUM_W-1:0] n
  );
    return (n > NUM_W'(DEPTH)) ? NUM_W'(DEPTH) : n;
  endfunction

endpackage

// File: rtl/knn_point_streamer_if.sv
// Memory read port plus lane output stream of the point streamer.
// master = streamer side, slave = memory / distance-lane side.
interface knn_point_streamer_if;
  import knn_pkg::*;

  logic                     o_rd_en;
  logic [ADDR_W-1:0]        o_rd_addr;
  logic [REGISTER_SIZE-1:0] i_rd_x0;
  logic [REGISTER_SIZE-1:0] i_rd_x1;
  logic [REGISTER_SIZE-1:0] i_rd_x2;
  logic [REGISTER_SIZE-1:0] i_rd_x3;
  logic [REGISTER_SIZE-2:0] i_rd_y0;
  logic [REGISTER_SIZE-2:0] i_rd_y1;
  logic [REGISTER_SIZE-2:0] i_rd_y2;
  logic [REGISTER_SIZE-2:0] i_rd_y3;

  logic                     o_valid;
  logic                     i_ready;
  logic [REGISTER_SIZE-1:0] o_x0;
  logic [REGISTER_SIZE-1:0] o_x1;
  logic [REGISTER_SIZE-1:0] o_x2;
  logic [REGISTER_SIZE-1:0] o_x3;
  logic [REGISTER_SIZE-2:0] o_y0;
  logic [REGISTER_SIZE-2:0] o_y1;
  logic [REGISTER_SIZE-2:0] o_y2;
  logic [REGISTER_SIZE-2:0] o_y3;
  logic [LANES-1:0]         o_lane_mask;
  logic                     o_last;

  modport master (
    output o_rd_en, o_rd_addr,
    input  i_rd_x0, i_rd_x1, i_rd_x2, i_rd_x3,
    input  i_rd_y0, i_rd_y1, i_rd_y2, i_rd_y3,
    output o_valid,
    input  i_ready,
    output o_x0, o_x1, o_x2, o_x3,
    output o_y0, o_y1, o_y2, o_y3,
    output o_lane_mask, o_last
  );

  modport slave (
    input  o_rd_en, o_rd_addr,
    output i_rd_x0, i_rd_x1, i_rd_x2, i_rd_x3,
    output i_rd_y0, i_rd_y1, i_rd_y2, i_rd_y3,
    input  o_valid,
    output i_ready,
    input  o_x0, o_x1, o_x2, o_x3,
    input  o_y0, o_y1, o_y2, o_y3,
    input  o_lane_mask, o_last
  );

endinterface

// File: rtl/knn_row_fifo.sv
// Two-entry row buffer between the memory read port and the lanes.
// Caller guarantees no push when full and no pop when empty.
module knn_row_fifo
  import knn_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  row_t       din,
  input  logic       pop,
  output row_t       dout,
  output logic [1:0] count,
  output logic       empty
);

  row_t       mem_q [2];
  row_t       mem_d [2];
  logic       wr_q, wr_d;
  logic       rd_q, rd_d;
  logic [1:0] cnt_q, cnt_d;

  // Pointer, storage and occupancy updates for push/pop.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = din;
      wr_d        = ~wr_q;
    end
    if (pop) begin
      rd_d = ~rd_q;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;
  assign empty = (cnt_q == 2'd0);

endmodule

// File: rtl/knn_point_streamer.sv
// Walks the training-point memory row by row and streams the rows
// to the distance lanes, buffering at most two rows in flight.
module knn_point_streamer
  import knn_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [NUM_W-1:0] i_num_points,
  output logic             o_busy,
  output logic             o_done,
  knn_point_streamer_if.master bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NUM_W-1:0]  n_q, n_d;
  logic              done_q, done_d;
  logic              infl_q, infl_d;
  logic [LANES-1:0]  imask_q, imask_d;
  logic              ilast_q, ilast_d;

  logic [NUM_W-3:0]  rows;
  logic              last_row;
  logic [LANES-1:0]  row_mask;
  logic [NUM_W-1:0]  n_start;
  logic [2:0]        outstanding;
  logic              pop;
  logic              rd_en;

  logic [LANES-1:0][REGISTER_SIZE-1:0] rd_x;
  logic [LANES-1:0][REGISTER_SIZE-2:0] rd_y;

  row_t              push_row;
  row_t              head;
  row_t              out_row;
  logic [1:0]        fifo_cnt;
  logic              fifo_empty;

  assign rd_x = {bus.i_rd_x3, bus.i_rd_x2,
                 bus.i_rd_x1, bus.i_rd_x0};
  assign rd_y = {bus.i_rd_y3, bus.i_rd_y2,
                 bus.i_rd_y1, bus.i_rd_y0};

  assign n_start  = clamp_n(i_num_points);
  assign rows     = n_q[NUM_W-1:2]
                  + {{(NUM_W-3){1'b0}}, |n_q[1:0]};
  assign last_row = ({1'b0, addr_q} == rows - 1'b1);
  assign pop      = ~fifo_empty & bus.i_ready;

  // Rows and reads already in flight, minus the beat leaving now.
  assign outstanding = {1'b0, fifo_cnt}
                     + {2'b00, infl_q}
                     - {2'b00, pop};

  assign rd_en = (state_q == S_READ) && (outstanding < 3'd2);

  // Lane mask of the row being issued; only the last row is partial.
  always_comb begin
    row_mask = '1;
    if (last_row && (n_q[1:0] != 2'd0)) begin
      row_mask = ({{(LANES-1){1'b0}}, 1'b1} << n_q[1:0])
               - {{(LANES-1){1'b0}}, 1'b1};
    end
  end

  // Returned row with masked lanes forced to zero.
  always_comb begin
    push_row = '0;
    for (int i = 0; i < LANES; i++) begin
      if (imask_q[i]) begin
        push_row.p[i].x = rd_x[i];
        push_row.p[i].y = rd_y[i];
      end
    end
    push_row.mask = imask_q;
    push_row.last = ilast_q;
  end

  // Sequencer next-state: start, row issue and final drain.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    n_d     = n_q;
    done_d  = 1'b0;
    infl_d  = rd_en;
    imask_d = imask_q;
    ilast_d = ilast_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          n_d    = n_start;
          addr_d = '0;
          if (n_start == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (rd_en) begin
          addr_d  = addr_q + 1'b1;
          imask_d = row_mask;
          ilast_d = last_row;
          if (last_row) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pop && head.last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      n_q     <= '0;
      done_q  <= 1'b0;
      infl_q  <= 1'b0;
      imask_q <= '0;
      ilast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      n_q     <= n_d;
      done_q  <= done_d;
      infl_q  <= infl_d;
      imask_q <= imask_d;
      ilast_q <= ilast_d;
    end
  end

  knn_row_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (infl_q),
    .din   (push_row),
    .pop   (pop),
    .dout  (head),
    .count (fifo_cnt),
    .empty (fifo_empty)
  );

  assign out_row = fifo_empty ? '0 : head;

  assign o_busy        = (state_q != S_IDLE);
  assign o_done        = done_q;
  assign bus.o_rd_en   = rd_en;
  assign bus.o_rd_addr = addr_q;
  assign bus.o_valid   = ~fifo_empty;
  assign bus.o_x0      = out_row.p[0].x;
  assign bus.o_x1      = out_row.p[1].x;
  assign bus.o_x2      = out_row.p[2].x;
  assign bus.o_x3      = out_row.p[3].x;
  assign bus.o_y0      = out_row.p[0].y;
  assign bus.o_y1      = out_row.p[1].y;
  assign bus.o_y2      = out_row.p[2].y;
  assign bus.o_y3      = out_row.p[3].y;
  assign bus.o_lane_mask = out_row.mask;
  assign bus.o_last    = out_row.last;

endmodule

// File: tb/tb_knn_point_streamer.sv
// Scoreboard bench for knn_point_streamer: point-indexed reference
// beats are queued at start and popped by an independent monitor.
module tb_knn_point_streamer;
  import knn_pkg::*;

  typedef struct packed {
    logic [3:0][10:0] x;
    logic [3:0][9:0]  y;
    logic [3:0]       mask;
    logic             last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic [7:0] i_num_points = 8'd0;
  logic       o_busy;
  logic       o_done;

  knn_point_streamer_if bus();

  knn_point_streamer dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_num_points (i_num_points),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  beat_t exp_q[$];
  int    mem_base = 0;
  logic  pend_en = 1'b0;
  logic [4:0] pend_addr = '0;
  int    exp_addr = 0;
  int    rd_cnt = 0;
  int    beats = 0;
  int    done_cnt = 0;
  int    first_valid = -1;
  int    last_hs = -1;
  int    done_cyc = -1;
  int    t_start = 0;
  int    issued = 0;
  int    accepted = 0;
  int    ready_mode = 0;
  bit    done_seen = 0;
  bit    busy_seen = 0;
  bit    prev_stall = 0;
  logic [127:0] prev_snap = '0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, req);
    end
  endtask

  function automatic logic [10:0] mx(input logic [4:0] a,
                                     input int l);
    return 11'(mem_base + 4 * int'(a) + l);
  endfunction

  function automatic logic [9:0] my(input logic [4:0] a,
                                    input int l);
    return 10'(mem_base + 4 * int'(a) + l + 1);
  endfunction

  function automatic logic [127:0] snap();
    return 128'({bus.o_valid,
                 bus.o_x3, bus.o_x2, bus.o_x1, bus.o_x0,
                 bus.o_y3, bus.o_y2, bus.o_y1, bus.o_y0,
                 bus.o_lane_mask, bus.o_last});
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: 1-cycle read latency, garbage when not read.
  always @(negedge clk) begin
    pend_en   <= bus.o_rd_en;
    pend_addr <= bus.o_rd_addr;
  end

  always @(posedge clk) begin
    if (pend_en) begin
      bus.i_rd_x0 <= mx(pend_addr, 0);
      bus.i_rd_x1 <= mx(pend_addr, 1);
      bus.i_rd_x2 <= mx(pend_addr, 2);
      bus.i_rd_x3 <= mx(pend_addr, 3);
      bus.i_rd_y0 <= my(pend_addr, 0);
      bus.i_rd_y1 <= my(pend_addr, 1);
      bus.i_rd_y2 <= my(pend_addr, 2);
      bus.i_rd_y3 <= my(pend_addr, 3);
    end else begin
      bus.i_rd_x0 <= 11'($urandom);
      bus.i_rd_x1 <= 11'($urandom);
      bus.i_rd_x2 <= 11'($urandom);
      bus.i_rd_x3 <= 11'($urandom);
      bus.i_rd_y0 <= 10'($urandom);
      bus.i_rd_y1 <= 10'($urandom);
      bus.i_rd_y2 <= 10'($urandom);
      bus.i_rd_y3 <= 10'($urandom);
    end
  end

  initial begin
    bus.i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.i_ready = 1'b1;
        1: bus.i_ready = ~bus.i_ready;
        default: bus.i_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: scoreboard pop, stall hold, address order, budget.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      issued     = 0;
      accepted   = 0;
      prev_stall = 0;
    end else begin
      if (o_busy) busy_seen = 1;
      if (bus.o_rd_en) begin
        chk("rd_addr", 128'(bus.o_rd_addr), 128'(exp_addr));
        exp_addr++;
        rd_cnt++;
        issued++;
      end
      if (prev_stall) chk("stall_hold", snap(), prev_snap);
      if (bus.o_valid && first_valid < 0) first_valid = cyc;
      if (bus.o_valid && bus.i_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 128'(1), 128'(0));
        end else begin
          e = exp_q.pop_front();
          chk("beat_x", 128'({bus.o_x3, bus.o_x2,
                              bus.o_x1, bus.o_x0}), 128'(e.x));
          chk("beat_y", 128'({bus.o_y3, bus.o_y2,
                              bus.o_y1, bus.o_y0}), 128'(e.y));
          chk("beat_mask", 128'(bus.o_lane_mask), 128'(e.mask));
          chk("beat_last", 128'(bus.o_last), 128'(e.last));
        end
        beats++;
        last_hs = cyc;
        accepted++;
      end
      if (o_busy) begin
        chk("outstanding_le2",
            128'((issued - accepted) <= 2), 128'(1));
      end
      if (o_done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_seen = 1;
      end
      prev_stall = bus.o_valid && !bus.i_ready;
      prev_snap  = snap();
    end
  end

  function automatic int clampn(input int n);
    return (n > 128) ? 128 : n;
  endfunction

  task automatic launch(input int n, input bit base0);
    int    nn;
    int    r;
    int    idx;
    beat_t e;
    nn = clampn(n);
    r  = (nn + 3) / 4;
    mem_base = base0 ? 0 : int'($urandom_range(0, 1500));
    exp_addr = 0;
    rd_cnt = 0;
    beats = 0;
    done_cnt = 0;
    first_valid = -1;
    last_hs = -1;
    done_cyc = -1;
    done_seen = 0;
    busy_seen = 0;
    for (int k = 0; k < r; k++) begin
      e = '0;
      for (int i = 0; i < 4; i++) begin
        idx = 4 * k + i;
        if (idx < nn) begin
          e.x[i]    = 11'(mem_base + idx);
          e.y[i]    = 10'(mem_base + idx + 1);
          e.mask[i] = 1'b1;
        end
      end
      e.last = (k == r - 1);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    i_start      = 1'b1;
    i_num_points = 8'(n);
    t_start      = cyc;
  endtask

  task automatic finish(input int n, input int extra_at);
    int nn;
    int r;
    bit to;
    nn = clampn(n);
    r  = (nn + 3) / 4;
    to = 1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      i_start = (extra_at > 0 && i == extra_at);
      if (i_start) i_num_points = 8'($urandom_range(1, 255));
      if (i == 0) begin
        if (nn > 0) begin
          chk("busy_t1", 128'(o_busy), 128'(1));
          chk("rd_en_t1", 128'(bus.o_rd_en), 128'(1));
          chk("rd_addr_t1", 128'(bus.o_rd_addr), 128'(0));
        end else begin
          chk("busy_n0", 128'(o_busy), 128'(0));
        end
      end
      if (done_seen) begin
        to = 0;
        break;
      end
    end
    if (to) chk("done_timeout", 128'(0), 128'(1));
    repeat (3) @(posedge clk);
    #1;
    chk("beat_count", 128'(beats), 128'(r));
    chk("queue_left", 128'(exp_q.size()), 128'(0));
    chk("rd_count", 128'(rd_cnt), 128'(r));
    chk("done_pulses", 128'(done_cnt), 128'(1));
    chk("busy_after", 128'(o_busy), 128'(0));
    if (nn == 0) begin
      chk("done_n0", 128'(done_cyc), 128'(t_start + 1));
      chk("busy_seen_n0", 128'(busy_seen), 128'(0));
    end else begin
      chk("first_valid", 128'(first_valid), 128'(t_start + 3));
      chk("done_after_last", 128'(done_cyc), 128'(last_hs + 1));
      if (ready_mode == 0) begin
        chk("last_beat_t", 128'(last_hs),
            128'(t_start + 2 + r));
        chk("done_t", 128'(done_cyc), 128'(t_start + 3 + r));
      end
    end
    exp_q.delete();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 128'(bus.o_valid), 128'(0));
    chk("rst_busy", 128'(o_busy), 128'(0));
    chk("rst_done", 128'(o_done), 128'(0));
    chk("rst_rd_en", 128'(bus.o_rd_en), 128'(0));
    chk("rst_rd_addr", 128'(bus.o_rd_addr), 128'(0));
    chk("rst_last", 128'(bus.o_last), 128'(0));
    chk("rst_mask", 128'(bus.o_lane_mask), 128'(0));
    chk("rst_x0", 128'(bus.o_x0), 128'(0));
    rst = 1'b0;

    ready_mode = 0;
    launch(128, 1);
    finish(128, 0);
    launch(6, 1);
    finish(6, 0);

    ready_mode = 1;
    launch(40, 0);
    finish(40, 0);

    ready_mode = 0;
    launch(0, 0);
    finish(0, 0);
    launch(200, 0);
    finish(200, 0);

    launch(128, 0);
    finish(128, 5);

    launch(128, 0);
    for (int i = 0; i < 200 && beats < 10; i++) begin
      @(posedge clk);
      #1;
      i_start = 1'b0;
    end
    chk("beats_before_rst", 128'(beats), 128'(10));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", 128'(bus.o_valid), 128'(0));
    chk("mid_rst_busy", 128'(o_busy), 128'(0));
    chk("mid_rst_rd_en", 128'(bus.o_rd_en), 128'(0));
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("post_rst_valid", 128'(bus.o_valid), 128'(0));
    launch(8, 0);
    finish(8, 0);

    ready_mode = 2;
    repeat (6) begin
      n = int'($urandom_range(1, 255));
      launch(n, 0);
      finish(n, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/knn_point_streamer.md
Name: knn_point_streamer

Overview:
Read-side sequencer for the KNN training-point memory. On a start pulse it walks the stored rows (4 points per row) from address 0 and issues reads to the memory read port, which has 1-cycle latency. It buffers the returned rows in a 2-entry FIFO and streams them to the distance-compute lanes over a valid/ready handshake. It is the consumer counterpart of the memory write path.

Parameters:
REGISTER_SIZE, 11, x coordinate width; y width is REGISTER_SIZE-1
DEPTH, 128, maximum stored points
LANES, 4, points per memory row and per output beat (fixed at 4)
ADDR_W, $clog2(DEPTH/LANES)=5, row address width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
i_start  in  1  single-cycle start pulse; ignored while o_busy=1
i_num_points  in  8  number of valid points, 0..255; values above DEPTH clamp to DEPTH
o_busy  out  1  high from the cycle after an accepted start until o_done
o_done  out  1  one-cycle pulse when the stream completes
o_rd_en  out  1  memory read strobe
o_rd_addr  out  ADDR_W  row address
i_rd_x0..i_rd_x3  in  REGISTER_SIZE  row x data, valid 1 cycle after o_rd_en
i_rd_y0..i_rd_y3  in  REGISTER_SIZE-1  row y data, same timing as x
o_valid  out  1  output beat valid
i_ready  in  1  downstream accepts beat
o_x0..o_x3  out  REGISTER_SIZE  lane x
o_y0..o_y3  out  REGISTER_SIZE-1  lane y
o_lane_mask  out  4  lane valid bits for the current beat
o_last  out  1  current beat is the final row

Behaviour:
- Reset: all outputs 0, FSM=IDLE, FIFO empty, in-flight flag cleared, row counters 0.
- Derived values: N = min(i_num_points, DEPTH), latched on start. R = ceil(N/4).
- FSM states:
  - IDLE: accepted start with N>0 goes to READ. With N=0, o_done pulses at T+1 and the FSM stays in IDLE; no o_rd_en is issued.
  - READ: issues rows 0..R-1 in order. Moves to DRAIN after the read of row R-1 is issued.
  - DRAIN: waits for the final handshake, pulses o_done the next cycle, then returns to IDLE.
- Read issue rule: o_rd_en=1 in a cycle iff state=READ and (fifo_occupancy + inflight - (o_valid&i_ready)) < 2. This guarantees no FIFO overflow and full throughput when i_ready=1.
- Read addressing: o_rd_addr increments by 1 per issued read. o_rd_addr holds its value when o_rd_en=0.
- Data capture: read data is captured into the FIFO in the cycle after o_rd_en. Each entry carries the 4 lanes plus its mask and last flag.
- Output: the FIFO head drives o_* directly, so o_valid = FIFO not empty. Outputs hold stable while o_valid=1 and i_ready=0.
- Timing with i_ready held high, start accepted at cycle T:
  - o_rd_en first asserts at T+1.
  - o_valid first asserts at T+3.
  - One beat per cycle thereafter; last beat at T+2+R.
  - o_done pulses at T+3+R.
- Lane mask: 4'b1111 for every row except the last. On the last row, lane i is valid iff i < (N mod 4), or all lanes if N mod 4 = 0. Masked lanes drive x=0 and y=0.
- o_last=1 only with the beat for row R-1.
- i_start while busy is ignored; it does not affect N or the counters.
- Simultaneous FIFO push and pop: occupancy is unchanged.
- rst mid-operation: the next cycle is in the reset state. Read data returned in the cycle after rst is discarded. A subsequent start restarts at address 0.
- No combinational path from i_ready to o_rd_addr. o_rd_en may depend combinationally on i_ready.

Decomposition:
- Shared package knn_pkg: REGISTER_SIZE, DEPTH, LANES, the point_t struct {x, y}, the row_t struct {point_t p[4], mask, last}, and the FSM state enum.
- Sub-module knn_row_fifo: 2-entry synchronous FIFO of row_t, with push/pop/occupancy.

Test Plan:
1. N=128, i_ready=1; memory model returns x=4*addr+lane, y=x+1 -> 32 consecutive beats from T+3; beat k has o_x0=4k; mask 1111; o_last on beat 31; o_done at T+35.
2. N=6 -> 2 beats; beat 1 has mask 0011, o_x0=4, o_x1=5, o_x2=o_x3=0, o_last=1; o_done 1 cycle after that handshake.
3. N=40 with i_ready toggling 1,0,1,0 -> exactly 10 beats in order with no duplicates; outputs stable while stalled; reads in flight plus FIFO occupancy never exceed 2.
4. N=0 -> o_done at T+1, o_rd_en never asserted, o_busy stays 0; N=200 -> clamps to 32 beats.
5. Second i_start during the stream -> ignored; beat count and N unchanged.
6. rst asserted after beat 10 -> next cycle o_valid=0, o_busy=0, FIFO empty; new start with N=8 -> o_rd_addr restarts at 0 and 2 beats are delivered.
